// File: rtl/ps2_digit_entry_if.sv
// Bundle of the PS/2 pins and the number handshake toward the consumer.
// The master side drives pins and ack; the slave side is the entry block.
interface ps2_digit_entry_if #(
    parameter int NUM_DIGITS = 3
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic                    PS2_CLK;
    logic                    PS2_DATA;
    logic                    iAck;
    logic [4*NUM_DIGITS-1:0] oDigits;
    logic [CW-1:0]           oCount;
    logic                    oNumRdy;
    logic                    oErr;

    modport master (
        output PS2_CLK, PS2_DATA, iAck,
        input  oDigits, oCount, oNumRdy, oErr
    );

    modport slave (
        input  PS2_CLK, PS2_DATA, iAck,
        output oDigits, oCount, oNumRdy, oErr
    );
endinterface

// File: rtl/ps2_digit_entry.sv
// PS/2 numeric entry: frame receiver with watchdog, break-code decoder and a
// two-state entry FSM that assembles a BCD number and holds it until acked.
//
// state    | meaning
// ST_ENTRY | collecting digits, editing keys active
// ST_READY | number complete, held until iAck
module ps2_digit_entry #(
    parameter int NUM_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               CLK,
    input  logic               reset,
    ps2_digit_entry_if.slave   bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {ST_ENTRY, ST_READY} state_t;

    logic [1:0]              clk_sync_q, dat_sync_q;
    logic                    clk_prev_q;
    logic                    fall;
    logic                    sd;
    logic [3:0]              idx_q;
    logic [9:0]              frame_q;
    logic [WW-1:0]           wd_q;
    logic                    rx_valid_q;
    logic [7:0]              rx_byte_q;
    logic                    err_q;
    logic                    brk_q, ext_q;
    logic                    is_prefix, key_act;
    logic                    is_digit, is_bs, is_esc, is_ent;
    logic [3:0]              key_digit;
    state_t                  state_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [CW-1:0]           cnt_q;
    logic                    rdy_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], bus.PS2_DATA};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign sd   = dat_sync_q[1];

    // frame_q shifts right so that after ten bits [0]=start, [8:1]=data, [9]=parity
    always_ff @(posedge CLK) begin
        if (reset) begin
            idx_q      <= 4'd0;
            frame_q    <= 10'd0;
            wd_q       <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if (fall) begin
                wd_q <= '0;
                if (idx_q == 4'd10) begin
                    if (!frame_q[0] && sd && (^frame_q[9:1])) begin
                        rx_valid_q <= 1'b1;
                        rx_byte_q  <= frame_q[8:1];
                    end else begin
                        err_q <= 1'b1;
                    end
                    idx_q <= 4'd0;
                end else begin
                    frame_q <= {sd, frame_q[9:1]};
                    idx_q   <= idx_q + 4'd1;
                end
            end else if (idx_q != 4'd0) begin
                if (wd_q == WW'(TIMEOUT_CYCLES)) begin
                    idx_q <= 4'd0;
                    wd_q  <= '0;
                    err_q <= 1'b1;
                end else begin
                    wd_q <= wd_q + WW'(1);
                end
            end
        end
    end

    always_comb begin
        is_digit  = 1'b0;
        is_bs     = 1'b0;
        is_esc    = 1'b0;
        is_ent    = 1'b0;
        key_digit = 4'd0;
        case (rx_byte_q)
            8'h45: begin is_digit = 1'b1; key_digit = 4'd0; end
            8'h16: begin is_digit = 1'b1; key_digit = 4'd1; end
            8'h1E: begin is_digit = 1'b1; key_digit = 4'd2; end
            8'h26: begin is_digit = 1'b1; key_digit = 4'd3; end
            8'h25: begin is_digit = 1'b1; key_digit = 4'd4; end
            8'h2E: begin is_digit = 1'b1; key_digit = 4'd5; end
            8'h36: begin is_digit = 1'b1; key_digit = 4'd6; end
            8'h3D: begin is_digit = 1'b1; key_digit = 4'd7; end
            8'h3E: begin is_digit = 1'b1; key_digit = 4'd8; end
            8'h46: begin is_digit = 1'b1; key_digit = 4'd9; end
            8'h66: is_bs  = 1'b1;
            8'h76: is_esc = 1'b1;
            8'h5A: is_ent = 1'b1;
            default: ;
        endcase
    end

    assign is_prefix = (rx_byte_q == 8'hF0) || (rx_byte_q == 8'hE0);
    assign key_act   = rx_valid_q && !is_prefix && brk_q && !ext_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else if (rx_valid_q) begin
            if (rx_byte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else if (rx_byte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_ENTRY;
            digits_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (key_act) begin
                        if (is_digit && cnt_q != CW'(NUM_DIGITS)) begin
                            for (int i = 0; i < NUM_DIGITS; i++)
                                if (i == int'(cnt_q)) digits_q[4*i +: 4] <= key_digit;
                            cnt_q <= cnt_q + CW'(1);
                        end else if (is_bs && cnt_q != '0) begin
                            for (int i = 0; i < NUM_DIGITS; i++)
                                if (i == int'(cnt_q) - 1) digits_q[4*i +: 4] <= 4'd0;
                            cnt_q <= cnt_q - CW'(1);
                        end else if (is_esc) begin
                            digits_q <= '0;
                            cnt_q    <= '0;
                        end else if (is_ent && cnt_q == CW'(NUM_DIGITS)) begin
                            state_q <= ST_READY;
                            rdy_q   <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (bus.iAck) begin
                        state_q  <= ST_ENTRY;
                        digits_q <= '0;
                        cnt_q    <= '0;
                        rdy_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_ENTRY;
            endcase
        end
    end

    assign bus.oDigits = digits_q;
    assign bus.oCount  = cnt_q;
    assign bus.oNumRdy = rdy_q;
    assign bus.oErr    = err_q;
endmodule

// File: tb/tb_ps2_digit_entry.sv
// Bench for ps2_digit_entry: drives PS/2 frames and compares against a
// key-level model (digit queue plus ready flag).
module tb_ps2_digit_entry;
    localparam int N   = 3;
    localparam int TO  = 200;
    localparam int H   = 5;
    localparam int GAP = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_digit_entry_if #(.NUM_DIGITS(N)) ifc();
    ps2_digit_entry #(.NUM_DIGITS(N), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk), .reset(rst), .bus(ifc.slave)
    );

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    always @(posedge clk) if (ifc.oErr === 1'b1) err_cnt++;

    int mq[$];
    bit m_rdy = 0, m_brk = 0, m_ext = 0;

    function automatic int code_digit(input logic [7:0] c);
        case (c)
            8'h45: return 0; 8'h16: return 1; 8'h1E: return 2; 8'h26: return 3;
            8'h25: return 4; 8'h2E: return 5; 8'h36: return 6; 8'h3D: return 7;
            8'h3E: return 8; 8'h46: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic logic [4*N-1:0] exp_digits();
        logic [4*N-1:0] v;
        v = '0;
        foreach (mq[i]) v[4*i +: 4] = 4'(mq[i]);
        return v;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        bit act;
        int d;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            act = m_brk && !m_ext;
            m_brk = 0;
            m_ext = 0;
            if (act && !m_rdy) begin
                d = code_digit(b);
                if (d >= 0) begin
                    if (mq.size() < N) mq.push_back(d);
                end else if (b == 8'h66) begin
                    if (mq.size() > 0) void'(mq.pop_back());
                end else if (b == 8'h76) mq.delete();
                else if (b == 8'h5A && mq.size() == N) m_rdy = 1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) ifc.PS2_DATA = bits[i];
            repeat (H) @(negedge clk);
            ifc.PS2_CLK = 1'b0;
            repeat (H) @(negedge clk);
            ifc.PS2_CLK = 1'b1;
        end
        ifc.PS2_DATA = 1'b1;
        repeat (GAP) @(negedge clk);
        if (!bad_par) model_byte(b);
    endtask

    task automatic press(input logic [7:0] c);
        send_frame(c, 0);
        send_frame(8'hF0, 0);
        send_frame(c, 0);
    endtask

    task automatic pulse_ack();
        @(negedge clk) ifc.iAck = 1'b1;
        if (m_rdy) begin m_rdy = 0; mq.delete(); end
        @(negedge clk) ifc.iAck = 1'b0;
    endtask

    task automatic test_reset();
        ifc.PS2_CLK = 1'b1; ifc.PS2_DATA = 1'b1; ifc.iAck = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.oDigits !== '0 || ifc.oCount !== '0 || ifc.oNumRdy !== 1'b0 || ifc.oErr !== 1'b0) begin
            failures++;
            $display("FAIL reset: digits=%h cnt=%0d rdy=%b err=%b required 0 0 0 0",
                     ifc.oDigits, ifc.oCount, ifc.oNumRdy, ifc.oErr);
        end
    endtask

    task automatic test_basic();
        press(8'h16); press(8'h1E); press(8'h26); press(8'h5A);
        checks++;
        if (ifc.oDigits !== 12'h321 || ifc.oCount !== 2'd3 || ifc.oNumRdy !== 1'b1) begin
            failures++;
            $display("FAIL basic_entry: digits=%h cnt=%0d rdy=%b required 321 3 1",
                     ifc.oDigits, ifc.oCount, ifc.oNumRdy);
        end
        pulse_ack();
        checks++;
        if (ifc.oDigits !== 12'h000 || ifc.oCount !== 2'd0 || ifc.oNumRdy !== 1'b0) begin
            failures++;
            $display("FAIL basic_ack: digits=%h cnt=%0d rdy=%b required 000 0 0",
                     ifc.oDigits, ifc.oCount, ifc.oNumRdy);
        end
    endtask

    task automatic test_backspace();
        press(8'h66);
        checks++;
        if (ifc.oCount !== 2'd0 || ifc.oDigits !== 12'h000) begin
            failures++;
            $display("FAIL bs_at_zero: cnt=%0d digits=%h required 0 000", ifc.oCount, ifc.oDigits);
        end
        press(8'h25); press(8'h2E); press(8'h66);
        checks++;
        if (ifc.oCount !== 2'd1 || ifc.oDigits !== 12'h004) begin
            failures++;
            $display("FAIL bs_remove: cnt=%0d digits=%h required 1 004", ifc.oCount, ifc.oDigits);
        end
        press(8'h3D); press(8'h3E); press(8'h5A);
        checks++;
        if (ifc.oDigits !== 12'h874 || ifc.oNumRdy !== 1'b1) begin
            failures++;
            $display("FAIL bs_entry: digits=%h rdy=%b required 874 1", ifc.oDigits, ifc.oNumRdy);
        end
        pulse_ack();
    endtask

    task automatic test_limits();
        press(8'h16); press(8'h1E); press(8'h5A);
        checks++;
        if (ifc.oNumRdy !== 1'b0 || ifc.oCount !== 2'd2) begin
            failures++;
            $display("FAIL short_enter: rdy=%b cnt=%0d required 0 2", ifc.oNumRdy, ifc.oCount);
        end
        press(8'h26); press(8'h36);
        checks++;
        if (ifc.oDigits !== 12'h321 || ifc.oCount !== 2'd3) begin
            failures++;
            $display("FAIL fourth_digit: digits=%h cnt=%0d required 321 3", ifc.oDigits, ifc.oCount);
        end
        press(8'h76);
        checks++;
        if (ifc.oDigits !== 12'h000 || ifc.oCount !== 2'd0) begin
            failures++;
            $display("FAIL esc: digits=%h cnt=%0d required 000 0", ifc.oDigits, ifc.oCount);
        end
        press(8'h16); press(8'h16); press(8'h16); press(8'h5A);
        press(8'h1E); press(8'h76); press(8'h66);
        checks++;
        if (ifc.oDigits !== 12'h111 || ifc.oCount !== 2'd3 || ifc.oNumRdy !== 1'b1) begin
            failures++;
            $display("FAIL keys_in_ready: digits=%h cnt=%0d rdy=%b required 111 3 1",
                     ifc.oDigits, ifc.oCount, ifc.oNumRdy);
        end
        pulse_ack();
    endtask

    task automatic test_parity();
        int e0;
        e0 = err_cnt;
        send_frame(8'hF0, 1);
        send_frame(8'h16, 0);
        checks++;
        if (err_cnt - e0 !== 1 || ifc.oCount !== 2'd0) begin
            failures++;
            $display("FAIL parity_err: pulses=%0d cnt=%0d required 1 0", err_cnt - e0, ifc.oCount);
        end
        send_frame(8'hF0, 0);
        send_frame(8'h16, 0);
        checks++;
        if (ifc.oDigits !== 12'h001 || ifc.oCount !== 2'd1) begin
            failures++;
            $display("FAIL parity_recover: digits=%h cnt=%0d required 001 1", ifc.oDigits, ifc.oCount);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) ifc.PS2_DATA = (i == 0) ? 1'b0 : 1'b1;
            repeat (H) @(negedge clk);
            ifc.PS2_CLK = 1'b0;
            repeat (H) @(negedge clk);
            ifc.PS2_CLK = 1'b1;
        end
        ifc.PS2_DATA = 1'b1;
        repeat (TO + 40) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL timeout_err: pulses=%0d required 1", err_cnt - e0);
        end
        send_frame(8'hF0, 0);
        send_frame(8'h1E, 0);
        checks++;
        if (ifc.oDigits !== 12'h021 || ifc.oCount !== 2'd2 || err_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL timeout_recover: digits=%h cnt=%0d pulses=%0d required 021 2 1",
                     ifc.oDigits, ifc.oCount, err_cnt - e0);
        end
    endtask

    task automatic test_extended();
        press(8'h26);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h5A, 0);
        checks++;
        if (ifc.oNumRdy !== 1'b0 || ifc.oCount !== 2'd3) begin
            failures++;
            $display("FAIL ext_enter: rdy=%b cnt=%0d required 0 3", ifc.oNumRdy, ifc.oCount);
        end
        send_frame(8'hF0, 0); send_frame(8'h5A, 0);
        checks++;
        if (ifc.oNumRdy !== 1'b1 || ifc.oDigits !== 12'h321) begin
            failures++;
            $display("FAIL plain_enter: rdy=%b digits=%h required 1 321", ifc.oNumRdy, ifc.oDigits);
        end
        pulse_ack();
    endtask

    task automatic test_random();
        logic [7:0] pool [15] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46, 8'h66, 8'h76, 8'h5A, 8'h1C, 8'h29};
        logic [7:0] c;
        int e0, r;
        e0 = err_cnt;
        for (int n = 0; n < 36; n++) begin
            r = $urandom_range(0, 9);
            c = pool[$urandom_range(0, 14)];
            if (r == 0) begin
                send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(c, 0);
            end else if (r == 1) begin
                pulse_ack();
            end else if (r == 2) begin
                press(8'h5A);
            end else begin
                press(c);
            end
            checks++;
            if (ifc.oDigits !== exp_digits() || ifc.oCount !== 2'(mq.size()) || ifc.oNumRdy !== m_rdy) begin
                failures++;
                $display("FAIL random_step%0d: digits=%h cnt=%0d rdy=%b required %h %0d %b",
                         n, ifc.oDigits, ifc.oCount, ifc.oNumRdy, exp_digits(), mq.size(), m_rdy);
            end
        end
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL random_no_err: pulses=%0d required 0", err_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backspace();
        test_limits();
        test_parity();
        test_timeout();
        test_extended();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
